// File: rtl/video_line_scaler.sv
// Line-ring video scaler: stores source lines in LINES slots and replays them on the display
// timing with fractional horizontal/vertical stepping, optional pillarbox borders, 2-clk pixel latency.
module video_line_scaler #(
  parameter int               PIX_W      = 24,
  parameter int               MAX_W      = 1024,
  parameter int               LINES      = 4,
  parameter int               FRAC       = 12,
  parameter int               PILLAR_W   = 160,
  parameter logic [PIX_W-1:0] BORDER_RGB = {PIX_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_src_pix_en,
  input  logic             i_src_de,
  input  logic             i_src_vsync,
  input  logic [PIX_W-1:0] i_src_rgb,
  input  logic             i_dst_pix_en,
  input  logic             i_dst_de,
  input  logic             i_dst_vsync,
  input  logic [15:0]      i_h_step,
  input  logic [15:0]      i_v_step,
  input  logic             i_pillar,
  output logic [PIX_W-1:0] o_dst_rgb,
  output logic             o_dst_de,
  output logic             o_frame_end,
  output logic             o_overrun,
  output logic             o_underrun
);

  localparam int XW = $clog2(MAX_W);
  localparam int LW = $clog2(LINES);
  localparam int AW = LW + XW;
  localparam int HW = FRAC + XW + 1;
  localparam int VW = FRAC + 2;
  localparam int CW = 16;
  localparam logic [15:0]   ONE_STEP  = 16'd1 << FRAC;
  localparam logic [VW-1:0] V_ONE     = {2'b01, {FRAC{1'b0}}};
  localparam logic [VW-1:0] V_FRAC    = {2'b00, {FRAC{1'b1}}};
  localparam logic [XW:0]   X_LAST    = (XW+1)'(MAX_W - 1);
  localparam logic [XW:0]   X_ONE     = (XW+1)'(1'b1);
  localparam logic [LW-1:0] L_ONE     = LW'(1'b1);
  localparam logic [LW-1:0] AVAIL_MAX = LW'(LINES - 1);
  localparam logic [CW:0]   PIL       = (CW+1)'(PILLAR_W);

  logic [PIX_W-1:0] mem_r [LINES*MAX_W];

  logic             src_vs_d_r, dst_vs_d_r, src_de_d_r, dst_de_d_r;
  logic [LW-1:0]    wr_line_r, rd_line_r, disp_line_r, avail_r;
  logic [XW:0]      wr_x_r;
  logic [VW-1:0]    v_acc_r, v_acc_nxt_s;
  logic [HW-1:0]    h_acc_r, h_eff_s, h_next_s;
  logic [CW-1:0]    x_r, width_r, x_eff_s, width_eff_s;
  logic             width_vld_r, wvld_eff_s;
  logic [AW-1:0]    addr_r;
  logic             v1_r, de1_r, bord1_r;
  logic [PIX_W-1:0] rgb_r;
  logic             de_r, frame_end_r, overrun_r, underrun_r;

  logic        src_vs_rise_s, dst_vs_rise_s, commit_s, wr_en_s, pix_s, line_start_s;
  logic        consume_req_s, consume_ok_s, underrun_s, overrun_s, border_s;
  logic [15:0] h_step_s, v_step_s;
  logic [16:0] v_sum_s;
  logic [XW:0] h_int_s;
  logic [XW-1:0] col_s;
  logic [LW-1:0] line_eff_s;

  assign src_vs_rise_s = i_src_vsync & ~src_vs_d_r;
  assign dst_vs_rise_s = i_dst_vsync & ~dst_vs_d_r;
  assign commit_s      = i_src_pix_en & src_de_d_r & ~i_src_de & ~src_vs_rise_s;
  assign wr_en_s       = i_src_pix_en & i_src_de & ~wr_x_r[XW] & ~src_vs_rise_s;
  assign pix_s         = i_dst_pix_en & i_dst_de;
  assign line_start_s  = pix_s & ~dst_de_d_r;
  assign h_step_s      = (i_h_step == 16'd0) ? ONE_STEP : i_h_step;
  assign v_step_s      = (i_v_step == 16'd0) ? ONE_STEP : i_v_step;

  // A commit in the same clock lets a consume proceed even when the ring looks empty.
  assign v_sum_s       = {{(17-VW){1'b0}}, v_acc_r} + {1'b0, v_step_s};
  assign consume_req_s = line_start_s & (|v_sum_s[16:FRAC]);
  assign consume_ok_s  = consume_req_s & ((|avail_r) | commit_s);
  assign underrun_s    = consume_req_s & ~consume_ok_s;
  assign overrun_s     = commit_s & (avail_r == AVAIL_MAX) & ~consume_ok_s;

  // First pixel of a line sees a fresh column counter, accumulator and line slot.
  assign x_eff_s     = line_start_s ? {CW{1'b0}} : x_r;
  assign h_eff_s     = line_start_s ? {HW{1'b0}} : h_acc_r;
  assign width_eff_s = line_start_s ? x_r : width_r;
  assign wvld_eff_s  = line_start_s ? (|x_r) : width_vld_r;
  assign line_eff_s  = consume_ok_s ? rd_line_r : disp_line_r;
  assign h_int_s     = h_eff_s[HW-1:FRAC];
  assign col_s       = (h_int_s > X_LAST) ? X_LAST[XW-1:0] : h_int_s[XW-1:0];
  assign border_s    = i_pillar & ((({1'b0, x_eff_s}) < PIL) |
                       (wvld_eff_s & (({1'b0, x_eff_s} + PIL) >= {1'b0, width_eff_s})));
  assign h_next_s    = border_s ? h_eff_s : (h_eff_s + HW'(h_step_s));

  // Vertical phase update: one consume per display line, integer part dropped on underrun.
  always_comb begin
    v_acc_nxt_s = v_acc_r;
    if (dst_vs_rise_s) begin
      v_acc_nxt_s = {VW{1'b0}};
    end else if (consume_ok_s) begin
      v_acc_nxt_s = v_sum_s[VW-1:0] - V_ONE;
    end else if (underrun_s) begin
      v_acc_nxt_s = v_sum_s[VW-1:0] & V_FRAC;
    end else if (line_start_s) begin
      v_acc_nxt_s = v_sum_s[VW-1:0];
    end else begin
      v_acc_nxt_s = v_acc_r;
    end
  end

  // Source side: write pointer, ring occupancy and read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_vs_d_r <= 1'b0;
      src_de_d_r <= 1'b0;
      wr_line_r  <= {LW{1'b0}};
      wr_x_r     <= {(XW+1){1'b0}};
      rd_line_r  <= {LW{1'b0}};
      avail_r    <= {LW{1'b0}};
    end else begin
      src_vs_d_r <= i_src_vsync;
      if (i_src_pix_en) src_de_d_r <= i_src_de;
      if (src_vs_rise_s) begin
        wr_line_r <= {LW{1'b0}};
        wr_x_r    <= {(XW+1){1'b0}};
        rd_line_r <= {LW{1'b0}};
        avail_r   <= {LW{1'b0}};
      end else begin
        if (commit_s) begin
          wr_line_r <= wr_line_r + L_ONE;
          wr_x_r    <= {(XW+1){1'b0}};
        end else if (wr_en_s) begin
          wr_x_r    <= wr_x_r + X_ONE;
        end
        if (consume_ok_s || overrun_s) rd_line_r <= rd_line_r + L_ONE;
        case ({commit_s & ~overrun_s, consume_ok_s})
          2'b10:   avail_r <= avail_r + L_ONE;
          2'b01:   avail_r <= avail_r - L_ONE;
          default: avail_r <= avail_r;
        endcase
      end
    end
  end

  // Line buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[{wr_line_r, wr_x_r[XW-1:0]}] <= i_src_rgb;
  end

  // Display side: line/column tracking and phase accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_vs_d_r  <= 1'b0;
      dst_de_d_r  <= 1'b0;
      v_acc_r     <= {VW{1'b0}};
      h_acc_r     <= {HW{1'b0}};
      x_r         <= {CW{1'b0}};
      width_r     <= {CW{1'b0}};
      width_vld_r <= 1'b0;
      disp_line_r <= {LW{1'b0}};
    end else begin
      dst_vs_d_r <= i_dst_vsync;
      v_acc_r    <= v_acc_nxt_s;
      if (i_dst_pix_en) dst_de_d_r <= i_dst_de;
      if (consume_ok_s) disp_line_r <= rd_line_r;
      if (line_start_s) begin
        width_r     <= width_eff_s;
        width_vld_r <= wvld_eff_s;
      end
      if (pix_s) begin
        x_r     <= x_eff_s + 16'd1;
        h_acc_r <= h_next_s;
      end
    end
  end

  // Two-stage output pipe: address register, then buffer read into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r        <= 1'b0;
      de1_r       <= 1'b0;
      bord1_r     <= 1'b1;
      addr_r      <= {AW{1'b0}};
      rgb_r       <= BORDER_RGB;
      de_r        <= 1'b0;
      frame_end_r <= 1'b0;
      overrun_r   <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      v1_r        <= i_dst_pix_en;
      frame_end_r <= src_vs_rise_s;
      overrun_r   <= overrun_s;
      underrun_r  <= underrun_s;
      if (i_dst_pix_en) begin
        addr_r  <= {line_eff_s, col_s};
        de1_r   <= i_dst_de;
        bord1_r <= ~i_dst_de | border_s;
      end
      if (v1_r) begin
        de_r  <= de1_r;
        rgb_r <= bord1_r ? BORDER_RGB : mem_r[addr_r];
      end
    end
  end

  assign o_dst_rgb   = rgb_r;
  assign o_dst_de    = de_r;
  assign o_frame_end = frame_end_r;
  assign o_overrun   = overrun_r;
  assign o_underrun  = underrun_r;

endmodule

// File: tb/tb_video_line_scaler.sv
// Scoreboard bench for video_line_scaler: expected pixels queued per display line, popped and
// compared two clocks after each display strobe.
module tb_video_line_scaler;

  localparam logic [23:0] BORDER = 24'hA5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_src_pix_en, i_src_de, i_src_vsync;
  logic [23:0] i_src_rgb;
  logic        i_dst_pix_en, i_dst_de, i_dst_vsync;
  logic [15:0] i_h_step, i_v_step;
  logic        i_pillar;
  logic [23:0] o_dst_rgb;
  logic        o_dst_de, o_frame_end, o_overrun, o_underrun;

  typedef struct packed {logic de; logic [23:0] rgb;} exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [23:0] mid_rgb;
  logic        mid_de, mid_under, s_over, fe_hi, fe_lo;

  video_line_scaler #(
    .PIX_W(24), .MAX_W(16), .LINES(4), .FRAC(12), .PILLAR_W(2), .BORDER_RGB(BORDER)
  ) dut (
    .clk(clk), .rst(rst),
    .i_src_pix_en(i_src_pix_en), .i_src_de(i_src_de), .i_src_vsync(i_src_vsync),
    .i_src_rgb(i_src_rgb),
    .i_dst_pix_en(i_dst_pix_en), .i_dst_de(i_dst_de), .i_dst_vsync(i_dst_vsync),
    .i_h_step(i_h_step), .i_v_step(i_v_step), .i_pillar(i_pillar),
    .o_dst_rgb(o_dst_rgb), .o_dst_de(o_dst_de), .o_frame_end(o_frame_end),
    .o_overrun(o_overrun), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  task automatic src_strobe(input logic de, input logic [23:0] rgb);
    i_src_pix_en = 1'b1; i_src_de = de; i_src_rgb = rgb;
    @(posedge clk); #1;
    i_src_pix_en = 1'b0;
    s_over = o_overrun;
  endtask

  task automatic src_line(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) src_strobe(1'b1, base + 24'(i));
    src_strobe(1'b0, 24'h000000);
  endtask

  task automatic dst_strobe(input logic de);
    i_dst_pix_en = 1'b1; i_dst_de = de;
    @(posedge clk); #1;
    i_dst_pix_en = 1'b0;
    mid_rgb = o_dst_rgb; mid_de = o_dst_de; mid_under = o_underrun;
    @(posedge clk); #1;
  endtask

  task automatic frame_sync();
    i_src_vsync = 1'b1; i_dst_vsync = 1'b1;
    @(posedge clk); #1;
    fe_hi = o_frame_end;
    i_src_vsync = 1'b0; i_dst_vsync = 1'b0;
    @(posedge clk); #1;
    fe_lo = o_frame_end;
  endtask

  task automatic test_reset();
    n_cmp++; if (o_dst_rgb !== BORDER) begin n_err++; $display("FAIL reset_rgb: got %h expected %h", o_dst_rgb, BORDER); end
    n_cmp++; if (o_dst_de !== 1'b0) begin n_err++; $display("FAIL reset_de: got %b expected 0", o_dst_de); end
    n_cmp++; if (o_frame_end !== 1'b0) begin n_err++; $display("FAIL reset_frame_end: got %b expected 0", o_frame_end); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
    n_cmp++; if (o_underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", o_underrun); end
  endtask

  // Unity scale: ramp replayed, then repeated with an underrun when no new line exists.
  task automatic test_unity();
    exp_t e, prev;
    i_h_step = 16'h1000; i_v_step = 16'h1000; i_pillar = 1'b0;
    frame_sync();
    n_cmp++; if (fe_hi !== 1'b1) begin n_err++; $display("FAIL frame_end_pulse: got %b expected 1", fe_hi); end
    n_cmp++; if (fe_lo !== 1'b0) begin n_err++; $display("FAIL frame_end_width: got %b expected 0", fe_lo); end
    src_line(24'h000000, 8);
    prev = {1'b0, BORDER};
    for (int ln = 0; ln < 2; ln++) begin
      exp_q.push_back({1'b0, BORDER});
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 24'(i)});
      for (int i = 0; i < 9; i++) begin
        dst_strobe(i != 0);
        n_cmp++;
        if (mid_rgb !== prev.rgb || mid_de !== prev.de) begin
          n_err++; $display("FAIL unity_hold l%0d p%0d: got %b/%h expected %b/%h", ln, i, mid_de, mid_rgb, prev.de, prev.rgb);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
          n_err++; $display("FAIL unity_px l%0d p%0d: got %b/%h expected %b/%h", ln, i, o_dst_de, o_dst_rgb, e.de, e.rgb);
        end
        if (i == 1) begin
          n_cmp++;
          if (mid_under !== (ln == 1)) begin
            n_err++; $display("FAIL underrun l%0d: got %b expected %b", ln, mid_under, ln == 1);
          end
        end
        prev = e;
      end
    end
  endtask

  task automatic test_hscale();
    exp_t e;
    i_h_step = 16'h0800; i_v_step = 16'h1000;
    frame_sync();
    src_line(24'h000100, 4);
    exp_q.push_back({1'b0, BORDER});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 24'h000100 + 24'(i / 2)});
    for (int i = 0; i < 9; i++) begin
      dst_strobe(i != 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
        n_err++; $display("FAIL hscale p%0d: got %b/%h expected %b/%h", i, o_dst_de, o_dst_rgb, e.de, e.rgb);
      end
    end
  endtask

  // Half vertical step: after the first (phase-priming) line, each source line shows twice.
  task automatic test_vscale();
    exp_t e;
    i_h_step = 16'h1000; i_v_step = 16'h0800;
    frame_sync();
    src_line(24'h000200, 4);
    src_line(24'h000300, 4);
    for (int i = 0; i < 5; i++) dst_strobe(i != 0);
    for (int ln = 0; ln < 4; ln++) begin
      exp_q.push_back({1'b0, BORDER});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, ((ln < 2) ? 24'h000200 : 24'h000300) + 24'(i)});
      for (int i = 0; i < 5; i++) begin
        dst_strobe(i != 0);
        e = exp_q.pop_front();
        n_cmp++;
        if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
          n_err++; $display("FAIL vscale l%0d p%0d: got %b/%h expected %b/%h", ln, i, o_dst_de, o_dst_rgb, e.de, e.rgb);
        end
      end
    end
  endtask

  task automatic test_pillar();
    exp_t e;
    i_h_step = 16'h1000; i_v_step = 16'h1000; i_pillar = 1'b1;
    frame_sync();
    src_line(24'h000400, 8);
    src_line(24'h000500, 8);
    for (int i = 0; i < 13; i++) dst_strobe(i != 0);
    exp_q.push_back({1'b0, BORDER});
    for (int x = 0; x < 12; x++)
      exp_q.push_back({1'b1, (x < 2 || x >= 10) ? BORDER : (24'h000500 + 24'(x - 2))});
    for (int i = 0; i < 13; i++) begin
      dst_strobe(i != 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
        n_err++; $display("FAIL pillar p%0d: got %b/%h expected %b/%h", i, o_dst_de, o_dst_rgb, e.de, e.rgb);
      end
    end
    i_pillar = 1'b0;
  endtask

  task automatic test_overrun();
    exp_t e;
    frame_sync();
    for (int k = 0; k < 4; k++) begin
      src_line(24'h000600 + 24'(k * 16), 4);
      n_cmp++;
      if (s_over !== (k == 3)) begin
        n_err++; $display("FAIL overrun commit%0d: got %b expected %b", k, s_over, k == 3);
      end
    end
    exp_q.push_back({1'b0, BORDER});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 24'h000610 + 24'(i)});
    for (int i = 0; i < 5; i++) begin
      dst_strobe(i != 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
        n_err++; $display("FAIL overrun_oldest_lost p%0d: got %b/%h expected %b/%h", i, o_dst_de, o_dst_rgb, e.de, e.rgb);
      end
    end
  endtask

  task automatic test_reset_midline();
    exp_t e;
    src_strobe(1'b1, 24'h7FF7FF);
    src_strobe(1'b1, 24'h7FF7FF);
    dst_strobe(1'b0);
    exp_q.push_back({1'b1, 24'h000620});
    dst_strobe(1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
      n_err++; $display("FAIL pre_reset_px: got %b/%h expected %b/%h", o_dst_de, o_dst_rgb, e.de, e.rgb);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (o_dst_rgb !== BORDER) begin n_err++; $display("FAIL async_reset_rgb: got %h expected %h", o_dst_rgb, BORDER); end
    n_cmp++; if (o_dst_de !== 1'b0) begin n_err++; $display("FAIL async_reset_de: got %b expected 0", o_dst_de); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    i_dst_de = 1'b0;
    frame_sync();
    n_cmp++; if (fe_hi !== 1'b1) begin n_err++; $display("FAIL post_reset_frame_end: got %b expected 1", fe_hi); end
    src_line(24'h000700, 4);
    exp_q.push_back({1'b0, BORDER});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 24'h000700 + 24'(i)});
    for (int i = 0; i < 5; i++) begin
      dst_strobe(i != 0);
      e = exp_q.pop_front();
      n_cmp++;
      if (o_dst_rgb !== e.rgb || o_dst_de !== e.de) begin
        n_err++; $display("FAIL post_reset_slot0 p%0d: got %b/%h expected %b/%h", i, o_dst_de, o_dst_rgb, e.de, e.rgb);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_src_pix_en = 1'b0; i_src_de = 1'b0; i_src_vsync = 1'b0; i_src_rgb = 24'h000000;
    i_dst_pix_en = 1'b0; i_dst_de = 1'b0; i_dst_vsync = 1'b0;
    i_h_step = 16'h1000; i_v_step = 16'h1000; i_pillar = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_unity();
    test_hscale();
    test_vscale();
    test_pillar();
    test_overrun();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
